// File: rtl/led_zone_pkg.sv
// led_zone_pkg: shared types and size helpers for the zone mean accumulator.
//   rgb_t      : packed {r,g,b} pixel at the default channel width
//   state_t    : IDLE / ACCUM / DRAIN
//   sum_w()    : exact width of one zone channel sum
//   mean_shift(): right shift turning a zone sum into an OUT_W mean
package led_zone_pkg;

    localparam int CH_W_DEF = 8;

    typedef struct packed {
        logic [CH_W_DEF-1:0] r;
        logic [CH_W_DEF-1:0] g;
        logic [CH_W_DEF-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    function automatic int sum_w(input int ch_w, input int zw_log2, input int zh_log2);
        return ch_w + zw_log2 + zh_log2;
    endfunction

    function automatic int mean_shift(input int ch_w, input int out_w, input int zw_log2,
                                      input int zh_log2);
        return zw_log2 + zh_log2 + ch_w - out_w;
    endfunction

endpackage

// File: rtl/zone_raster_cnt.sv
// zone_raster_cnt: raster position tracker for the zone accumulator.
//   clk, rst_n : clock, synchronous active-low reset
//   i_load     : sof beat; the beat is pixel 0, counters move to position 1
//   i_step     : ordinary beat; counters advance by one pixel
//   o_zone     : row-major zone index of the pixel on the current beat
//   o_last     : current position is the final pixel of the frame
//   o_adv      : counters advance on this cycle
module zone_raster_cnt #(
    parameter  int ZONES_X = 4,
    parameter  int ZONES_Y = 4,
    parameter  int ZW_LOG2 = 5,
    parameter  int ZH_LOG2 = 4,
    localparam int ZIW     = $clog2(ZONES_X * ZONES_Y),
    localparam int XW      = (ZONES_X > 1) ? $clog2(ZONES_X) : 1,
    localparam int YW      = (ZONES_Y > 1) ? $clog2(ZONES_Y) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_load,
    input  logic           i_step,
    output logic [ZIW-1:0] o_zone,
    output logic           o_last,
    output logic           o_adv
);

    logic [ZW_LOG2-1:0] r_x_in, w_x_src;
    logic [XW-1:0]      r_zone_x, w_zx_src;
    logic [ZH_LOG2-1:0] r_y_in, w_y_src;
    logic [YW-1:0]      r_zone_y, w_zy_src;
    logic               w_x_wrap, w_zx_end, w_zx_wrap, w_y_wrap, w_zy_end;

    // A load restarts from pixel 0 and steps once, so both paths share one incrementer.
    always_comb begin
        w_x_src   = i_load ? '0 : r_x_in;
        w_zx_src  = i_load ? '0 : r_zone_x;
        w_y_src   = i_load ? '0 : r_y_in;
        w_zy_src  = i_load ? '0 : r_zone_y;
        w_x_wrap  = &w_x_src;
        w_zx_end  = w_zx_src == XW'(ZONES_X - 1);
        w_zx_wrap = w_x_wrap && w_zx_end;
        w_y_wrap  = w_zx_wrap && &w_y_src;
        w_zy_end  = w_zy_src == YW'(ZONES_Y - 1);
    end

    assign o_adv  = i_load | i_step;
    assign o_zone = ZIW'(r_zone_y) * ZIW'(ZONES_X) + ZIW'(r_zone_x);
    assign o_last = &r_x_in && (r_zone_x == XW'(ZONES_X - 1)) &&
                    &r_y_in && (r_zone_y == YW'(ZONES_Y - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x_in   <= '0;
            r_zone_x <= '0;
            r_y_in   <= '0;
            r_zone_y <= '0;
        end else if (o_adv) begin
            r_x_in   <= w_x_src + 1'b1;
            r_zone_x <= w_x_wrap ? (w_zx_end ? '0 : w_zx_src + 1'b1) : w_zx_src;
            r_y_in   <= w_zx_wrap ? w_y_src + 1'b1 : w_y_src;
            r_zone_y <= w_y_wrap ? (w_zy_end ? '0 : w_zy_src + 1'b1) : w_zy_src;
        end
    end

endmodule

// File: rtl/zone_mean_accum.sv
// zone_mean_accum: per-zone RGB mean calculator for an LED backlight grid.
//   clk, rst_n             : clock, synchronous active-low reset
//   pix_valid/ready/sof    : raster pixel stream handshake, sof marks top-left pixel
//   pix_data               : {R,G,B}, R in MSBs
//   mean_valid/ready       : result stream handshake, one zone per beat
//   mean_zone, mean_r/g/b  : row-major zone index and OUT_W-bit means
//   mean_last              : final zone of the frame
//   busy                   : not IDLE
//   frame_err              : one-cycle pulse after an sof that interrupts a frame
// Build option: define ZONE_MEAN_ROUND_EN for round-half-up means with saturation;
// otherwise means are truncated.
module zone_mean_accum
    import led_zone_pkg::*;
#(
    parameter  int CH_W    = 8,
    parameter  int OUT_W   = 4,
    parameter  int ZONES_X = 4,
    parameter  int ZONES_Y = 4,
    parameter  int ZW_LOG2 = 5,
    parameter  int ZH_LOG2 = 4,
    localparam int NZ      = ZONES_X * ZONES_Y,
    localparam int ZIW     = $clog2(NZ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              pix_sof,
    input  logic [3*CH_W-1:0] pix_data,
    output logic              mean_valid,
    input  logic              mean_ready,
    output logic [ZIW-1:0]    mean_zone,
    output logic [OUT_W-1:0]  mean_r,
    output logic [OUT_W-1:0]  mean_g,
    output logic [OUT_W-1:0]  mean_b,
    output logic              mean_last,
    output logic              busy,
    output logic              frame_err
);

    localparam int SUM_W = sum_w(CH_W, ZW_LOG2, ZH_LOG2);
    localparam int SH    = mean_shift(CH_W, OUT_W, ZW_LOG2, ZH_LOG2);
`ifdef ZONE_MEAN_ROUND_EN
    localparam int HALF  = (SH > 0) ? (1 << (SH - 1)) : 0;
    localparam int MAXV  = (1 << OUT_W) - 1;
`endif

    state_t                r_state;
    logic [ZIW-1:0]        r_drain;
    logic                  r_err;
    logic [2:0][SUM_W-1:0] r_sum [NZ];
    logic [2:0][SUM_W-1:0] w_pix, w_drain_sum;
    logic [ZIW-1:0]        w_zone;
    logic                  w_beat, w_load, w_step, w_adv, w_last_pix, w_out_hs;

    function automatic logic [OUT_W-1:0] scale(input logic [SUM_W-1:0] s);
`ifdef ZONE_MEAN_ROUND_EN
        logic [SUM_W:0] t;
        t = {1'b0, s} + (SUM_W + 1)'(HALF);
        return ((t >> SH) > (SUM_W + 1)'(MAXV)) ? OUT_W'(MAXV) : OUT_W'(t >> SH);
`else
        return OUT_W'(s >> SH);
`endif
    endfunction

    // DRAIN blocks the input side, so input and output handshakes never overlap.
    assign pix_ready = rst_n && (r_state != DRAIN);
    assign w_beat    = pix_valid && pix_ready;
    assign w_load    = w_beat && pix_sof;
    assign w_step    = w_beat && !pix_sof && (r_state == ACCUM);
    assign w_out_hs  = mean_valid && mean_ready;

    always_comb
        for (int c = 0; c < 3; c++)
            w_pix[c] = SUM_W'(pix_data[c*CH_W +: CH_W]);

    zone_raster_cnt #(
        .ZONES_X (ZONES_X),
        .ZONES_Y (ZONES_Y),
        .ZW_LOG2 (ZW_LOG2),
        .ZH_LOG2 (ZH_LOG2)
    ) u_raster (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_step (w_step),
        .o_zone (w_zone),
        .o_last (w_last_pix),
        .o_adv  (w_adv)
    );

    // An sof beat wipes every zone and seeds zone 0 with its own pixel.
    always_ff @(posedge clk) begin
        for (int z = 0; z < NZ; z++) begin
            if (!rst_n)
                r_sum[z] <= '0;
            else if (w_adv) begin
                if (w_load)
                    r_sum[z] <= (z == 0) ? w_pix : '0;
                else if (w_zone == ZIW'(z))
                    for (int c = 0; c < 3; c++)
                        r_sum[z][c] <= r_sum[z][c] + w_pix[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_drain <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_load && (r_state == ACCUM);
            case (r_state)
                IDLE:
                    if (w_load)
                        r_state <= ACCUM;
                ACCUM:
                    if (w_step && w_last_pix) begin
                        r_state <= DRAIN;
                        r_drain <= '0;
                    end
                DRAIN:
                    if (w_out_hs) begin
                        r_state <= mean_last ? IDLE : DRAIN;
                        r_drain <= mean_last ? '0 : r_drain + 1'b1;
                    end
                default:
                    r_state <= IDLE;
            endcase
        end
    end

    assign w_drain_sum = r_sum[r_drain];
    assign mean_valid  = r_state == DRAIN;
    assign mean_zone   = r_drain;
    assign mean_last   = mean_valid && (r_drain == ZIW'(NZ - 1));
    assign mean_r      = scale(w_drain_sum[2]);
    assign mean_g      = scale(w_drain_sum[1]);
    assign mean_b      = scale(w_drain_sum[0]);
    assign busy        = r_state != IDLE;
    assign frame_err   = r_err;

endmodule

// File: tb/tb_zone_mean_accum.sv
// tb_zone_mean_accum: randomized self-checking bench for zone_mean_accum.
module tb_zone_mean_accum;

    localparam int CH_W  = 8;
    localparam int OUT_W = 4;
    localparam int ZX    = 4;
    localparam int ZY    = 4;
    localparam int ZWL   = 5;
    localparam int ZHL   = 4;
    localparam int NZ    = ZX * ZY;
    localparam int ZIW   = 4;
    localparam int W     = ZX << ZWL;
    localparam int H     = ZY << ZHL;
    localparam int NPIX  = W * H;
    localparam int ZPIX  = (1 << ZWL) * (1 << ZHL);
    localparam int DIV   = ZPIX << (CH_W - OUT_W);
    localparam int MAXM  = (1 << OUT_W) - 1;

    logic              clk = 0;
    logic              rst_n = 0;
    logic              pix_valid = 0;
    logic              pix_sof = 0;
    logic [3*CH_W-1:0] pix_data = '0;
    logic              mean_ready = 0;
    logic              pix_ready, mean_valid, mean_last, busy, frame_err;
    logic [ZIW-1:0]    mean_zone;
    logic [OUT_W-1:0]  mean_r, mean_g, mean_b;

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;
    logic [3*CH_W-1:0] frame [NPIX];
    int exp_m [NZ][3];

    zone_mean_accum dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_sof    (pix_sof),
        .pix_data   (pix_data),
        .mean_valid (mean_valid),
        .mean_ready (mean_ready),
        .mean_zone  (mean_zone),
        .mean_r     (mean_r),
        .mean_g     (mean_g),
        .mean_b     (mean_b),
        .mean_last  (mean_last),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (frame_err === 1'b1)
            err_pulses++;

    function automatic int zone_of(input int p);
        return ((p / W) / (1 << ZHL)) * ZX + (p % W) / (1 << ZWL);
    endfunction

    task automatic fill(input int mode, input logic [3*CH_W-1:0] v);
        for (int p = 0; p < NPIX; p++) begin
            int k;
            k = zone_of(p);
            if (mode == 0)
                frame[p] = v;
            else if (mode == 1)
                frame[p] = {8'(k * 16), 8'h00, 8'(255 - k * 16)};
            else
                frame[p] = 24'($urandom);
        end
    endtask

    // Reference: plain per-zone channel sums divided by pixel count and channel scale.
    task automatic model();
        int s [NZ][3];
        for (int z = 0; z < NZ; z++)
            for (int c = 0; c < 3; c++)
                s[z][c] = 0;
        for (int p = 0; p < NPIX; p++)
            for (int c = 0; c < 3; c++)
                s[zone_of(p)][c] += int'(frame[p][c*CH_W +: CH_W]);
        for (int z = 0; z < NZ; z++)
            for (int c = 0; c < 3; c++) begin
`ifdef ZONE_MEAN_ROUND_EN
                exp_m[z][c] = (s[z][c] + DIV / 2) / DIV;
                if (exp_m[z][c] > MAXM)
                    exp_m[z][c] = MAXM;
`else
                exp_m[z][c] = s[z][c] / DIV;
`endif
            end
    endtask

    task automatic send_frame(input int n, input int gap);
        int p = 0;
        int stall = 0;
        while (p < n && stall < 50) begin
            @(negedge clk);
            pix_valid = ($urandom_range(99) >= gap);
            pix_sof   = (p == 0);
            pix_data  = frame[p];
            if (pix_valid && pix_ready)
                p++;
            else if (!pix_ready)
                stall++;
        end
        @(negedge clk);
        pix_valid = 0;
        pix_sof   = 0;
        checks++;
        if (p != n) begin
            errors++;
            $display("FAIL send: accepted %0d pixels, required %0d", p, n);
        end
    endtask

    // Entered on the negedge right after the final pixel was accepted.
    task automatic collect(input int bp, input int stop_at);
        int hs = 0;
        int cyc = 0;
        logic stalled = 0;
        logic [ZIW+3*OUT_W-1:0] held = '0;
        logic [ZIW+3*OUT_W:0] got, want;
        checks++;
        if (mean_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: mean_valid=%b one cycle after last pixel, required 1", mean_valid);
        end
        while (hs < stop_at && cyc < 400) begin
            cyc++;
            if (stalled) begin
                checks++;
                if ({mean_zone, mean_r, mean_g, mean_b} !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got %h, required %h", {mean_zone, mean_r, mean_g, mean_b}, held);
                end
            end
            checks++;
            if ({mean_valid, pix_ready, busy} !== 3'b101) begin
                errors++;
                $display("FAIL drain_flags: valid/ready/busy=%b, required 101", {mean_valid, pix_ready, busy});
            end
            mean_ready = ($urandom_range(99) >= bp);
            if (mean_ready) begin
                got  = {mean_zone, mean_r, mean_g, mean_b, mean_last};
                want = {ZIW'(hs), OUT_W'(exp_m[hs][2]), OUT_W'(exp_m[hs][1]), OUT_W'(exp_m[hs][0]),
                        hs == NZ - 1};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL result[%0d]: got zone/r/g/b/last=%h, required %h", hs, got, want);
                end
                hs++;
                stalled = 0;
            end else begin
                stalled = 1;
                held = {mean_zone, mean_r, mean_g, mean_b};
            end
            @(negedge clk);
        end
        mean_ready = 0;
        checks++;
        if (hs != stop_at) begin
            errors++;
            $display("FAIL drain_count: %0d handshakes, required %0d", hs, stop_at);
        end
        if (stop_at == NZ) begin
            checks++;
            if ({mean_valid, busy, pix_ready} !== 3'b001) begin
                errors++;
                $display("FAIL drain_end: valid/busy/ready=%b, required 001", {mean_valid, busy, pix_ready});
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: pix_ready=%b during reset, required 0", pix_ready);
        end
        checks++;
        if ({mean_valid, mean_last, frame_err, busy, mean_zone, mean_r, mean_g, mean_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {mean_valid, mean_last, frame_err, busy, mean_zone, mean_r, mean_g, mean_b});
        end
        rst_n = 1;
        @(negedge clk);
        checks++;
        if ({pix_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: ready/busy=%b, required 10", {pix_ready, busy});
        end
    endtask

    task automatic test_idle_discard();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pix_valid = 1;
            pix_sof   = 0;
            pix_data  = 24'($urandom);
        end
        @(negedge clk);
        pix_valid = 0;
        @(negedge clk);
        checks++;
        if ({busy, mean_valid, pix_ready} !== 3'b001 || err_pulses != 0) begin
            errors++;
            $display("FAIL idle_discard: busy/valid/ready=%b pulses=%0d, required 001 and 0",
                     {busy, mean_valid, pix_ready}, err_pulses);
        end
    endtask

    task automatic test_uniform();
        fill(0, 24'hFF8040);
        model();
        send_frame(NPIX, 0);
        collect(0, NZ);
        checks++;
        if (err_pulses != 0) begin
            errors++;
            $display("FAIL uniform_err: %0d frame_err pulses, required 0", err_pulses);
        end
    endtask

    task automatic test_gradient();
        fill(1, '0);
        model();
        send_frame(NPIX, 0);
        collect(0, NZ);
    endtask

    task automatic test_backpressure();
        fill(2, '0);
        model();
        send_frame(NPIX, 30);
        collect(50, NZ);
    endtask

    task automatic test_sof_error();
        int base;
        base = err_pulses;
        fill(2, '0);
        send_frame(3000, 0);
        fill(2, '0);
        model();
        send_frame(NPIX, 0);
        collect(0, NZ);
        checks++;
        if (err_pulses - base != 1) begin
            errors++;
            $display("FAIL sof_error: %0d frame_err pulses, required 1", err_pulses - base);
        end
    endtask

    task automatic test_reset_mid_drain();
        int seen = 0;
        fill(2, '0);
        model();
        send_frame(NPIX, 0);
        collect(0, 5);
        checks++;
        if (mean_zone !== 4'd5) begin
            errors++;
            $display("FAIL mid_drain_zone: zone=%0d before reset, required 5", mean_zone);
        end
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        checks++;
        if ({mean_valid, busy, mean_last, mean_zone, mean_r, mean_g, mean_b} !== '0) begin
            errors++;
            $display("FAIL mid_drain_reset: got %h, required 0",
                     {mean_valid, busy, mean_last, mean_zone, mean_r, mean_g, mean_b});
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mean_ready = 1;
            if (mean_valid)
                seen++;
        end
        mean_ready = 0;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL post_reset_results: %0d valid cycles, required 0", seen);
        end
    endtask

    task automatic test_rounding();
        fill(0, 24'h18F800);
        model();
        send_frame(NPIX, 0);
        collect(0, NZ);
    endtask

    initial begin
        test_reset();
        test_idle_discard();
        test_uniform();
        test_gradient();
        test_backpressure();
        test_sof_error();
        test_reset_mid_drain();
        test_rounding();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/zone_mean_accum.md
Name: zone_mean_accum

Overview:
- Parametrised successor of the fixed 16-zone LED backlight mean calculator.
- Accepts a raster RGB pixel stream with a valid/ready handshake and frame-start marker, and accumulates per-zone per-channel sums over a ZONES_X x ZONES_Y grid.
- At end of frame it computes each zone's mean, scaled to OUT_W bits, and streams one zone per handshake to the LED driver path.

Parameters:
- CH_W, 8, bits per colour channel.
- OUT_W, 4, bits per output mean channel (1..CH_W).
- ZONES_X, 4, zones per row.
- ZONES_Y, 4, zone rows.
- ZW_LOG2, 5, log2 zone width in pixels (32).
- ZH_LOG2, 4, log2 zone height in pixels (16).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- pix_valid  in  1  pixel beat valid
- pix_ready  out  1  block accepts pixel
- pix_sof  in  1  beat is first pixel of frame (top-left)
- pix_data  in  3*CH_W  {R,G,B}, R in MSBs
- mean_valid  out  1  zone result valid
- mean_ready  in  1  downstream accepts result
- mean_zone  out  $clog2(ZONES_X*ZONES_Y)  zone index, row-major
- mean_r, mean_g, mean_b  out  OUT_W each  zone means
- mean_last  out  1  marks final zone of frame
- busy  out  1  state != IDLE
- frame_err  out  1  one-cycle pulse on early sof

Behaviour:
- Interface: single clock clk; rst_n is synchronous and active-low.
- Derived sizes:
  - SUM_W = CH_W + ZW_LOG2 + ZH_LOG2; default 17.
  - NZ = ZONES_X*ZONES_Y.
  - Frame size = (ZONES_X<<ZW_LOG2) x (ZONES_Y<<ZH_LOG2).
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; all sums, counters and drain index are cleared.
  - mean_valid=0, mean_last=0, frame_err=0, busy=0, mean_zone=0, means=0.
  - pix_ready is forced 0 while rst_n=0.
- Accepted beat: pix_valid && pix_ready.
- IDLE:
  - pix_ready=1.
  - Beats without pix_sof are discarded silently.
  - A beat with pix_sof clears all sums, loads that pixel into zone 0, sets raster counters to position 1, and moves to ACCUM.
- ACCUM:
  - pix_ready=1.
  - Each accepted beat adds each channel to the current zone's sum.
  - Raster counters: x_in, zone_x, y_in, zone_y, each wrapping at its limit.
  - Zone index = zone_y*ZONES_X + zone_x.
  - When the final frame pixel is accepted, go to DRAIN next cycle with drain index 0.
  - Accepted pix_sof in ACCUM: frame_err pulses next cycle; the frame restarts exactly as the IDLE sof case.
- DRAIN:
  - pix_ready=0.
  - mean_valid=1; mean_zone = drain index.
  - Means come from the registered sums at the drain index; values hold stable while mean_valid && !mean_ready.
  - On handshake, drain index increments.
  - mean_last=1 at index NZ-1; its handshake returns the block to IDLE next cycle.
- Mean arithmetic (per channel):
  - mean = sum >> (ZW_LOG2 + ZH_LOG2 + CH_W - OUT_W), i.e. truncation.
  - Sums cannot overflow because SUM_W is exact.
- Latency:
  - mean_valid rises 1 cycle after the last-pixel accept.
  - With mean_ready held 1, drain takes NZ cycles.
  - A sof can be accepted the cycle after the last result handshake.
- Simultaneous events:
  - Input and output handshakes never coincide because pix_ready=0 in DRAIN.
  - Reset mid-ACCUM or mid-DRAIN aborts the frame; no partial results are emitted.

Optional Feature:
- ZONE_MEAN_ROUND_EN defined:
  - Means round half-up: add 1<<(S-1) before the shift by S.
  - Result saturates to 2^OUT_W-1.
- Undefined: plain truncation as above.
- Handshake and timing are identical in both cases.

Decomposition:
- Package led_zone_pkg holds:
  - rgb_t packed struct parametrised by CH_W (via localparam defaults).
  - state enum {IDLE, ACCUM, DRAIN}.
  - Helper functions sum_w() and mean_shift().
- Sub-module zone_raster_cnt (sequential) holds the four wrapping raster counters and outputs zone index, last_pixel, and advance-on-beat.
- Accumulator array and drain logic stay in the top.

Test Plan:
- Uniform 0xFF8040 frame (128x64, defaults), mean_ready=1 -> 16 results, zones 0..15, R=0xF G=0x8 B=0x4; mean_last only on zone 15; mean_valid high 16 consecutive cycles.
- Zone k filled with R=k*16, G=0, B=255-k*16 -> mean_r=k, mean_b=15-k for each zone.
- Random mean_ready backpressure (50%) -> values stable while stalled; exactly 16 handshakes; pix_ready=0 throughout DRAIN.
- Sof reasserted at pixel 3000, then full clean frame -> one frame_err pulse; results reflect only the second frame.
- Channel 0x18 / 0xF8 uniform -> without macro: 0x1 / 0xF; with ZONE_MEAN_ROUND_EN: 0x2 / 0xF (saturated).
- rst_n low for 1 cycle mid-DRAIN at zone 5 -> mean_valid=0 next cycle; no further results; next sof frame is correct.
